// File: rtl/vga_stream_out.sv
`default_nettype none
// ============================================================================
// Module   : vga_stream_out
// Purpose  : Parametrised raster timing generator (sync, data-enable,
//            coordinates) fed by a valid/ready pixel stream with a
//            start-of-frame marker. Pixels are buffered in a small FIFO.
//            Underflow or a misplaced/missing start-of-frame shows the
//            fallback colour, raises a sticky flag and resynchronises on a
//            later frame. Timing is never disturbed by stream errors.
// Revision : 1.0 - initial release
// ============================================================================
module vga_stream_out #(
   parameter int   CW         = 4,
   parameter int   H_ACTIVE   = 1280,
   parameter int   H_FRONT    = 72,
   parameter int   H_SYNC     = 80,
   parameter int   H_BACK     = 216,
   parameter int   V_ACTIVE   = 720,
   parameter int   V_FRONT    = 3,
   parameter int   V_SYNC     = 5,
   parameter int   V_BACK     = 22,
   parameter logic H_POL      = 1'b1,
   parameter logic V_POL      = 1'b1,
   parameter int   FIFO_DEPTH = 16
) (
   input  logic            vga_clk,
   input  logic            reset_n,
   input  logic [3*CW-1:0] s_data,
   input  logic            s_sof,
   input  logic            s_valid,
   output logic            s_ready,
   input  logic [3*CW-1:0] bg_color,
   input  logic            clr_err,
   output logic [CW-1:0]   vga_r,
   output logic [CW-1:0]   vga_g,
   output logic [CW-1:0]   vga_b,
   output logic            vga_hs,
   output logic            vga_vs,
   output logic            vga_de,
   output logic [15:0]     pixel_x,
   output logic [15:0]     pixel_y,
   output logic            frame_start,
   output logic            underflow,
   output logic            sync_err
);

   // Line/frame layout: sync, back porch, active, front porch.
   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [15:0] H_LAST      = 16'(H_TOTAL - 1);
   localparam logic [15:0] H_SYNC_END  = 16'(H_SYNC);
   localparam logic [15:0] H_ACT_START = 16'(H_SYNC + H_BACK);
   localparam logic [15:0] H_ACT_END   = 16'(H_SYNC + H_BACK + H_ACTIVE);
   localparam logic [15:0] V_LAST      = 16'(V_TOTAL - 1);
   localparam logic [15:0] V_SYNC_END  = 16'(V_SYNC);
   localparam logic [15:0] V_ACT_START = 16'(V_SYNC + V_BACK);
   localparam logic [15:0] V_ACT_END   = 16'(V_SYNC + V_BACK + V_ACTIVE);

   // FIFO geometry; an entry is {sof, pixel}.
   localparam int DW = 3 * CW;
   localparam int EW = DW + 1;
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

   // Stream-tracking state machine.
   localparam logic [1:0] S_WAIT_SOF = 2'd0;
   localparam logic [1:0] S_ARMED    = 2'd1;
   localparam logic [1:0] S_RUN      = 2'd2;

   // Raster counters
   logic [15:0] h_cnt_q, h_cnt_d;
   logic [15:0] v_cnt_q, v_cnt_d;

   // Decoded timing of the current counter state
   logic        hs_c, vs_c, hact_c, vact_c, de_c, first_px_c, origin_c;
   logic [15:0] hoff_c, voff_c;

   // FSM and FIFO
   logic [1:0]    state_q, state_d;
   logic [EW-1:0] fifo_mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          full_c, empty_c, accept_c;
   logic          push_req_c, push_c, pop_c, flush_c;
   logic          set_uf_c, set_se_c;
   logic [EW-1:0] head_c;
   logic          head_sof_c;
   logic [DW-1:0] head_data_c;

   // Registered outputs
   logic [DW-1:0] rgb_q, rgb_d;
   logic          hs_q, vs_q, de_q, fs_q;
   logic [15:0]   px_q, py_q;
   logic          underflow_q, underflow_d;
   logic          sync_err_q, sync_err_d;

   // Decode sync/active windows and the offsets into the active region
   always_comb begin
      hs_c       = (h_cnt_q < H_SYNC_END);
      vs_c       = (v_cnt_q < V_SYNC_END);
      hact_c     = (h_cnt_q >= H_ACT_START) && (h_cnt_q < H_ACT_END);
      vact_c     = (v_cnt_q >= V_ACT_START) && (v_cnt_q < V_ACT_END);
      de_c       = hact_c && vact_c;
      hoff_c     = h_cnt_q - H_ACT_START;
      voff_c     = v_cnt_q - V_ACT_START;
      first_px_c = (hoff_c == 16'd0) && (voff_c == 16'd0);
      origin_c   = (h_cnt_q == 16'd0) && (v_cnt_q == 16'd0);
   end

   // Advance the raster counters; v steps when h wraps
   always_comb begin
      h_cnt_d = h_cnt_q + 16'd1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_LAST) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == V_LAST) ? 16'd0 : v_cnt_q + 16'd1;
      end
   end

   // Full comes from the registered count so a same-cycle pop never frees a slot early
   assign full_c      = (count_q == FULL_CNT);
   assign empty_c     = (count_q == '0);
   assign s_ready     = ((state_q != S_RUN) && (state_q != S_ARMED)) || !full_c;
   assign accept_c    = s_valid && s_ready;
   assign head_c      = fifo_mem_q[rd_ptr_q];
   assign head_sof_c  = head_c[EW-1];
   assign head_data_c = head_c[DW-1:0];

   // Stream tracking: arm on sof, start at frame origin, check each popped beat
   always_comb begin
      state_d    = state_q;
      push_req_c = 1'b0;
      pop_c      = 1'b0;
      flush_c    = 1'b0;
      set_uf_c   = 1'b0;
      set_se_c   = 1'b0;
      rgb_d      = de_c ? bg_color : '0;
      case (state_q)
         S_WAIT_SOF: begin
            // Beats without sof are consumed and dropped here.
            if (accept_c && s_sof) begin
               push_req_c = 1'b1;
               state_d    = S_ARMED;
            end
         end
         S_ARMED: begin
            push_req_c = accept_c;
            if (origin_c && !empty_c) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            push_req_c = accept_c;
            if (de_c) begin
               if (empty_c) begin
                  set_uf_c = 1'b1;
                  flush_c  = 1'b1;
                  state_d  = S_WAIT_SOF;
               end else begin
                  pop_c = 1'b1;
                  if (head_sof_c != first_px_c) begin
                     set_se_c = 1'b1;
                     flush_c  = 1'b1;
                     state_d  = S_WAIT_SOF;
                  end else begin
                     rgb_d = head_data_c;
                  end
               end
            end
         end
         default: begin
            state_d = S_WAIT_SOF;
         end
      endcase
   end

   // FIFO pointers/count; a flush discards everything including a beat accepted this cycle
   always_comb begin
      push_c   = push_req_c && !full_c && !flush_c;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_c) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_c) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop_c) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         count_d = count_q + {{AW{1'b0}}, push_c} - {{AW{1'b0}}, pop_c};
      end
   end

   // Sticky flags; a new error wins over a simultaneous clear
   always_comb begin
      underflow_d = set_uf_c || (underflow_q && !clr_err);
      sync_err_d  = set_se_c || (sync_err_q && !clr_err);
   end

   // FIFO storage; contents need no reset since the count qualifies them
   always_ff @(posedge vga_clk) begin
      if (push_c) begin
         fifo_mem_q[wr_ptr_q] <= {s_sof, s_data};
      end
   end

   // Counter, FSM and FIFO control registers
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         h_cnt_q  <= '0;
         v_cnt_q  <= '0;
         state_q  <= S_WAIT_SOF;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         h_cnt_q  <= h_cnt_d;
         v_cnt_q  <= v_cnt_d;
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Output registers: one cycle behind the counter state
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         rgb_q       <= '0;
         hs_q        <= ~H_POL;
         vs_q        <= ~V_POL;
         de_q        <= 1'b0;
         fs_q        <= 1'b0;
         px_q        <= '0;
         py_q        <= '0;
         underflow_q <= 1'b0;
         sync_err_q  <= 1'b0;
      end else begin
         rgb_q       <= rgb_d;
         hs_q        <= hs_c ? H_POL : ~H_POL;
         vs_q        <= vs_c ? V_POL : ~V_POL;
         de_q        <= de_c;
         fs_q        <= origin_c;
         px_q        <= de_c ? hoff_c : 16'd0;
         py_q        <= de_c ? voff_c : 16'd0;
         underflow_q <= underflow_d;
         sync_err_q  <= sync_err_d;
      end
   end

   assign vga_r       = rgb_q[CW-1:0];
   assign vga_g       = rgb_q[2*CW-1:CW];
   assign vga_b       = rgb_q[3*CW-1:2*CW];
   assign vga_hs      = hs_q;
   assign vga_vs      = vs_q;
   assign vga_de      = de_q;
   assign pixel_x     = px_q;
   assign pixel_y     = py_q;
   assign frame_start = fs_q;
   assign underflow   = underflow_q;
   assign sync_err    = sync_err_q;

endmodule
`default_nettype wire
